// File: rtl/master_port_pkg.sv
// master_port_pkg: shared state type, default widths and bus_mode encodings for master_port
package master_port_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_DATA = 1'b1;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RWAIT, RDONE} state_t;
endpackage

// File: rtl/master_port_if.sv
// master_port_if: local master and serial bus signals of master_port with master/slave views
interface master_port_if
  import master_port_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();
  logic              m_req;
  logic              arbiter_grant;
  logic [DATA_W-1:0] m_data_out;
  logic              m_data_out_valid;
  logic [ADDR_W-1:0] m_address_out;
  logic              m_address_out_valid;
  logic              m_rw;
  logic              m_ready;
  logic              s_split;
  logic              s_ack;
  logic              bus_data_in_valid;
  logic              bus_data_in;
  logic              bus_data_out;
  logic              m_grant;
  logic [DATA_W-1:0] m_data_in;
  logic              m_data_in_valid;
  logic              bus_data_out_valid;
  logic              arbiter_req;
  logic              bus_mode;
  logic              m_ack;
  logic              bus_m_ready;
  logic              bus_m_rw;
  logic              m_split_ack;
  modport master (
    input  m_req, arbiter_grant, m_data_out, m_data_out_valid, m_address_out,
           m_address_out_valid, m_rw, m_ready, s_split, s_ack, bus_data_in_valid, bus_data_in,
    output bus_data_out, m_grant, m_data_in, m_data_in_valid, bus_data_out_valid, arbiter_req,
           bus_mode, m_ack, bus_m_ready, bus_m_rw, m_split_ack
  );
  modport slave (
    output m_req, arbiter_grant, m_data_out, m_data_out_valid, m_address_out,
           m_address_out_valid, m_rw, m_ready, s_split, s_ack, bus_data_in_valid, bus_data_in,
    input  bus_data_out, m_grant, m_data_in, m_data_in_valid, bus_data_out_valid, arbiter_req,
           bus_mode, m_ack, bus_m_ready, bus_m_rw, m_split_ack
  );
endinterface

// File: rtl/master_port.sv
// master_port: serialises address/write data onto a bit-serial bus and collects acknowledged read data
module master_port
  import master_port_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic           clk,
  input logic           rst,
  master_port_if.master bus
);
  localparam int CNT_W = $clog2(ADDR_W > DATA_W ? ADDR_W : DATA_W);
  localparam int RX_W = $clog2(DATA_W + 1);
  state_t                   state;
  logic [ADDR_W+DATA_W-1:0] sr;
  logic [CNT_W-1:0]         cnt;
  logic                     rw_q;
  logic [DATA_W-1:0]        rx_sr;
  logic [RX_W-1:0]          rx_cnt;
  logic                     ack_pending;
  logic [DATA_W-1:0]        data_q;
  logic                     valid_q;
  assign bus.m_grant = bus.arbiter_grant;
  assign bus.arbiter_req = bus.m_req;
  assign bus.bus_m_ready = bus.m_ready;
  assign bus.bus_m_rw = bus.m_rw;
  assign bus.m_split_ack = bus.s_split;
  assign bus.bus_data_out_valid = state == ADDR || state == WDATA;
  assign bus.bus_data_out = bus.bus_data_out_valid & sr[0];
  assign bus.bus_mode = (state == WDATA || state == RWAIT) ? MODE_DATA : MODE_ADDR;
  assign bus.m_ack = state == RDONE ? 1'b1 : state == RWAIT ? 1'b0 : bus.s_ack;
  assign bus.m_data_in = data_q;
  assign bus.m_data_in_valid = valid_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      rw_q        <= 1'b0;
      rx_sr       <= '0;
      rx_cnt      <= '0;
      ack_pending <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE:
          if (bus.m_address_out_valid && bus.arbiter_grant) begin
            sr     <= {bus.m_data_out, bus.m_address_out};
            rw_q   <= bus.m_rw;
            cnt    <= '0;
            rx_cnt <= '0;
            state  <= ADDR;
          end
        ADDR: begin
          sr  <= sr >> 1;
          cnt <= cnt == CNT_W'(ADDR_W - 1) ? '0 : cnt + 1'b1;
          if (cnt == CNT_W'(ADDR_W - 1)) state <= rw_q ? WDATA : RWAIT;
        end
        WDATA: begin
          sr  <= sr >> 1;
          cnt <= cnt == CNT_W'(DATA_W - 1) ? '0 : cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state <= IDLE;
        end
        RWAIT: begin
          if (bus.s_ack) ack_pending <= 1'b1;
          if (bus.bus_data_in_valid && rx_cnt != RX_W'(DATA_W)) begin
            rx_sr  <= {bus.bus_data_in, rx_sr[DATA_W-1:1]};
            rx_cnt <= rx_cnt + 1'b1;
          end
          if (rx_cnt == RX_W'(DATA_W) && (ack_pending || bus.s_ack)) begin
            data_q  <= rx_sr;
            valid_q <= 1'b1;
            state   <= RDONE;
          end
        end
        RDONE: begin
          ack_pending <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_master_port.sv
// tb_master_port: randomized self-checking bench for master_port against a bit-level transfer model
module tb_master_port;
  import master_port_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  int n_valid = 0;
  logic [7:0] last_rd = '0;
  bit have_rd = 1'b0;
  master_port_if #(.ADDR_W(16), .DATA_W(8)) bus ();
  master_port dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic idle_inputs();
    bus.m_req = 1'b0;
    bus.arbiter_grant = 1'b0;
    bus.m_data_out = '0;
    bus.m_data_out_valid = 1'b0;
    bus.m_address_out = '0;
    bus.m_address_out_valid = 1'b0;
    bus.m_rw = 1'b0;
    bus.m_ready = 1'b0;
    bus.s_split = 1'b0;
    bus.s_ack = 1'b0;
    bus.bus_data_in_valid = 1'b0;
    bus.bus_data_in = 1'b0;
  endtask
  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    logic [23:0] got = '0;
    int bad_v = 0;
    int bad_m = 0;
    bus.m_address_out = a;
    bus.m_data_out = d;
    bus.m_rw = 1'b1;
    bus.m_address_out_valid = 1'b1;
    bus.m_data_out_valid = 1'b1;
    bus.arbiter_grant = 1'b1;
    for (int c = 0; c < 26; c++) begin
      tick();
      bus.m_address_out_valid = 1'b0;
      bus.m_data_out_valid = 1'b0;
      bus.arbiter_grant = 1'($urandom);
      bus.m_rw = 1'($urandom);
      bus.m_data_out = 8'($urandom);
      bus.m_address_out = 16'($urandom);
      #1;
      if (c < 24) begin
        got[c] = bus.bus_data_out;
        bad_v += int'(bus.bus_data_out_valid !== 1'b1);
        bad_m += int'(bus.bus_mode !== (c < 16 ? MODE_ADDR : MODE_DATA));
      end else begin
        bad_v += int'(bus.bus_data_out_valid !== 1'b0);
        bad_m += int'(bus.bus_mode !== MODE_ADDR);
      end
    end
    check("wr_addr", 32'(got[15:0]), 32'(a));
    check("wr_data", 32'(got[23:16]), 32'(d));
    check("wr_valid_pattern", bad_v, 0);
    check("wr_mode_pattern", bad_m, 0);
    if (have_rd) check("rd_hold_over_wr", 32'(bus.m_data_in), 32'(last_rd));
  endtask
  task automatic do_read(input logic [15:0] a, input logic [7:0] d, input int d_start,
                         input bit gaps, input bit ack_from_last, input int ack_arg);
    int bc[8];
    int l, ack_c, last_c;
    int v_c = -1;
    int n_v = 0;
    int n_a = 0;
    int bad_v = 0;
    int bad_m = 0;
    logic a_at_v = 1'b0;
    logic [15:0] got = '0;
    logic [7:0] rd = '0;
    bc[0] = d_start;
    for (int k = 1; k < 8; k++) bc[k] = bc[k-1] + 1 + (gaps ? int'($urandom_range(0, 2)) : 0);
    l = bc[7];
    ack_c = ack_from_last ? l + ack_arg : ack_arg;
    last_c = (l > ack_c ? l : ack_c) + 6;
    bus.m_address_out = a;
    bus.m_data_out = 8'($urandom);
    bus.m_rw = 1'b0;
    bus.m_address_out_valid = 1'b1;
    bus.arbiter_grant = 1'b1;
    for (int c = 0; c <= last_c; c++) begin
      tick();
      bus.m_address_out_valid = (c > 0 && c < 15) ? 1'($urandom) : 1'b0;
      bus.arbiter_grant = 1'($urandom);
      bus.m_rw = 1'($urandom);
      bus.bus_data_in_valid = c < 16 ? 1'($urandom) : 1'b0;
      bus.bus_data_in = 1'($urandom);
      for (int k = 0; k < 8; k++)
        if (bc[k] == c) begin
          bus.bus_data_in_valid = 1'b1;
          bus.bus_data_in = d[k];
        end
      bus.s_ack = c == ack_c;
      #1;
      if (c < 16) begin
        got[c] = bus.bus_data_out;
        bad_v += int'(bus.bus_data_out_valid !== 1'b1);
        bad_m += int'(bus.bus_mode !== MODE_ADDR);
      end else begin
        bad_v += int'(bus.bus_data_out_valid !== 1'b0);
        n_a += int'(bus.m_ack === 1'b1);
        if (bus.m_data_in_valid === 1'b1) begin
          n_v++;
          v_c = c;
          rd = bus.m_data_in;
          a_at_v = bus.m_ack;
        end else if (v_c < 0) bad_m += int'(bus.bus_mode !== MODE_DATA);
        else bad_m += int'(bus.bus_mode !== MODE_ADDR);
      end
    end
    bus.s_ack = 1'b0;
    bus.bus_data_in_valid = 1'b0;
    check("rd_addr", 32'(got), 32'(a));
    check("rd_data", 32'(rd), 32'(d));
    check("rd_valid_count", n_v, 1);
    check("rd_ack_count", n_a, 1);
    check("rd_ack_with_valid", 32'(a_at_v), 1);
    check("rd_valid_timing", 32'(v_c > l && v_c > ack_c && v_c <= (l > ack_c ? l : ack_c) + 2), 1);
    check("rd_bus_valid_pattern", bad_v, 0);
    check("rd_mode_pattern", bad_m, 0);
    check("rd_hold", 32'(bus.m_data_in), 32'(d));
    n_valid += n_v;
    last_rd = d;
    have_rd = 1'b1;
  endtask
  initial begin
    logic [5:0] pt;
    idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", 32'({bus.bus_data_out, bus.bus_data_out_valid, bus.bus_mode, bus.m_data_in_valid}), 0);
    check("reset_data_in", 32'(bus.m_data_in), 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      pt = 6'($urandom);
      {bus.m_req, bus.arbiter_grant, bus.m_ready, bus.m_rw, bus.s_ack, bus.s_split} = pt;
      #1;
      check("passthrough", 32'({bus.arbiter_req, bus.m_grant, bus.bus_m_ready, bus.bus_m_rw, bus.m_ack, bus.m_split_ack}), 32'(pt));
    end
    idle_inputs();
    tick();
    do_write(16'hA55A, 8'h3C);
    tick();
    do_read(16'h1357, 8'h96, 18, 1'b0, 1'b0, 17);
    tick();
    do_read(16'h2468, 8'h69, 16, 1'b0, 1'b1, 1);
    tick();
    do_read(16'h9ACE, 8'hCC, 16, 1'b0, 1'b1, 2);
    check("valid_total", n_valid, 3);
    for (int i = 0; i < 12; i++) begin
      int ds;
      bit fl;
      tick();
      if ($urandom_range(0, 1) == 1) do_write(16'($urandom), 8'($urandom));
      else begin
        ds = 16 + int'($urandom_range(0, 4));
        fl = 1'($urandom);
        do_read(16'($urandom), 8'($urandom), ds, 1'b1, fl,
                fl ? int'($urandom_range(0, 3)) : int'($urandom_range(16, ds + 3)));
      end
    end
    tick();
    bus.m_address_out = 16'h1234;
    bus.m_data_out = 8'h77;
    bus.m_rw = 1'b1;
    bus.m_address_out_valid = 1'b1;
    bus.arbiter_grant = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      bus.m_address_out_valid = 1'b0;
      #1;
    end
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", 32'({bus.bus_data_out, bus.bus_data_out_valid, bus.bus_mode, bus.m_data_in_valid}), 0);
    check("rst_mid_data_in", 32'(bus.m_data_in), 0);
    have_rd = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
    do_write(16'h0F0F, 8'hA5);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/master_port.md
Name: master_port

Overview:
- Bus-master-side port between a local master and a bit-serial shared bus with an arbiter.
- Passes request/grant/control signals straight through.
- Write: serialises a 16-bit address then 8 data bits, LSB first.
- Read: serialises the address, deserialises 8 returned bits, and merges the target ACK into one m_ack pulse aligned with read-data-valid.

Parameters:
- ADDR_W, 16, address width, serialised first.
- DATA_W, 8, data width for write serialisation and read deserialisation.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_req  in  1  master bus request.
- arbiter_grant  in  1  grant from arbiter.
- m_data_out  in  DATA_W  write data from master.
- m_data_out_valid  in  1  write data valid.
- m_address_out  in  ADDR_W  address from master.
- m_address_out_valid  in  1  address valid; starts a transfer.
- m_rw  in  1  1=write, 0=read.
- m_ready  in  1  master ready.
- s_split  in  1  target split indication.
- s_ack  in  1  target acknowledge.
- bus_data_in_valid  in  1  serial read bit valid.
- bus_data_in  in  1  serial read bit.
- bus_data_out  out  1  serial address/data bit.
- m_grant  out  1  equals arbiter_grant.
- m_data_in  out  DATA_W  deserialised read data.
- m_data_in_valid  out  1  one-cycle read-complete pulse.
- bus_data_out_valid  out  1  bus_data_out carries a valid bit.
- arbiter_req  out  1  equals m_req.
- bus_mode  out  1  0=address phase or idle; 1=data phase (write data or awaiting/receiving read data).
- m_ack  out  1  acknowledge to master.
- bus_m_ready  out  1  equals m_ready.
- bus_m_rw  out  1  equals m_rw.
- m_split_ack  out  1  equals s_split.

Behaviour:
- Combinational pass-throughs, all states: m_grant, arbiter_req, bus_m_ready, bus_m_rw, m_split_ack.
- States: IDLE, ADDR, WDATA, RWAIT, RDONE. Reset (async) forces IDLE.
- Registered outputs reset to 0: m_data_in, m_data_in_valid, shift registers, counters, ack_pending.
- IDLE:
  - Start condition: m_address_out_valid & arbiter_grant at a clock edge.
  - On start, latch m_address_out, m_data_out and m_rw; go to ADDR with bit count 0.
  - Grant is checked only at start; a started transfer runs to completion.
- ADDR:
  - bus_data_out_valid=1, bus_mode=0, bus_data_out = address bit[count].
  - Bit 0 appears the cycle after the start edge; one bit per cycle, LSB first.
  - After bit ADDR_W-1: go to WDATA if latched rw=1, else RWAIT.
- WDATA:
  - bus_data_out_valid=1, bus_mode=1, DATA_W data bits LSB first, one per cycle.
  - Then IDLE; bus_mode returns to 0.
- RWAIT:
  - bus_mode=1, bus_data_out_valid=0.
  - Each cycle with bus_data_in_valid shifts bus_data_in into bit position [rx count], LSB first.
  - s_ack seen in any RWAIT cycle (before, during or after data bits) sets ack_pending.
  - Once DATA_W bits have been received and (ack_pending or s_ack): load m_data_in, go to RDONE.
  - Direct s_ack is masked to m_ack throughout RWAIT.
- RDONE: m_data_in_valid=1 and m_ack=1 for exactly one cycle; clear ack_pending; go to IDLE.
- m_ack in IDLE/ADDR/WDATA equals s_ack (combinational).
- m_data_in holds its value until the next read completes.
- bus_data_in_valid outside RWAIT is ignored. s_ack outside RWAIT does not set ack_pending.
- Idle outputs: bus_data_out=0, bus_data_out_valid=0, bus_mode=0.
- A start request during a transfer is ignored.
- Reset mid-transfer aborts to IDLE with no m_data_in_valid.

Decomposition:
- Shared package: state enum, ADDR_W/DATA_W defaults, bus_mode encodings (MODE_ADDR=0, MODE_DATA=1).
- No sub-module required; an optional serial_shifter (PISO) may be reused for the ADDR/WDATA path.

Test Plan:
- Write A55A/3C with grant and rw=1 -> 24 valid serial bits, LSB first; first 16 equal A55A with bus_mode=0; last 8 equal 3C with bus_mode=1; bus_mode=0 two cycles later.
- Pass-through: toggle m_req, arbiter_grant, m_ready, m_rw, s_ack, s_split in IDLE -> arbiter_req, m_grant, bus_m_ready, bus_m_rw, m_ack, m_split_ack match.
- Read 1357, s_ack one cycle before data bits, data 96 -> address serialised with bus_mode=0; bus_mode=1 after; no m_ack before m_data_in_valid; one m_ack coincident with m_data_in=96.
- Read 2468, s_ack the cycle after the last data bit, data 69 -> m_data_in=69; exactly one m_ack, coincident with valid.
- Read 9ACE, s_ack 2 cycles after data, data CC -> valid and m_ack only after ack; total of 3 m_data_in_valid pulses across the three reads.
- Assert rst during ADDR phase -> immediate IDLE, all registered outputs 0, next transfer restarts at bit 0.
